pipe_flush_ctrl: RTL

PIPE_FLUSH_CTRL -- requirements
Module: pipe_flush_ctrl

---
 rtl/pipe_flush_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipe_flush_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_flush_ctrl
//
// Fetch-PC generator and per-stage squash controller for a 4-stage front end
// (F, D, E, M). Every cycle it picks the next fetch address from the branch
// predictor's select and the candidate targets. It keeps one squash flag per
// stage. These flags turn wrong-path or stalled slots into bubbles. It also
// counts mispredictions and latches any illegal select code.
//
// Ports
//   clk            in   1   single clock, all state updates on the rising edge
//   rst            in   1   synchronous active-high reset
//   pcmux_sel      in   3   next-PC select:
//                           0 = PC+4, 1 = F-predicted target, 3 = JAL target,
//                           4 = JALR target, 5 = resolved branch target,
//                           2/6/7 = illegal (treated as PC+4)
//   predict_fail   in   1   branch in E mispredicted. It forces select 5.
//   stall          in   1   load-use hazard. It holds F and D.
//   pred_target    in  32   predicted target (select 1)
//   jal_target     in  32   JAL target (select 3)
//   jalr_target    in  32   JALR target (select 4)
//   br_target      in  32   resolved branch target (select 5)
//   pcF            out 32   registered fetch PC
//   killF..killM   out  1   registered squash flags (1 = bubble in that stage)
//   redirect       out  1   one-cycle strobe: pcF was loaded non-sequentially
//   mispredict_cnt out 16   saturating count of predict_fail events
//   illegal_sel    out  1   sticky flag for an illegal select code
// -----------------------------------------------------------------------------
module pipe_flush_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  pcmux_sel,
  input  logic        predict_fail,
  input  logic        stall,
  input  logic [31:0] pred_target,
  input  logic [31:0] jal_target,
  input  logic [31:0] jalr_target,
  input  logic [31:0] br_target,
  output logic [31:0] pcF,
  output logic        killF,
  output logic        killD,
  output logic        killE,
  output logic        killM,
  output logic        redirect,
  output logic [15:0] mispredict_cnt,
  output logic        illegal_sel
);

  localparam logic [2:0] SEL_SEQ  = 3'd0;
  localparam logic [2:0] SEL_PRED = 3'd1;
  localparam logic [2:0] SEL_JAL  = 3'd3;
  localparam logic [2:0] SEL_JALR = 3'd4;
  localparam logic [2:0] SEL_BR   = 3'd5;

  // Saturating increment. The counter sticks at all-ones and never wraps.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    sat_inc16 = (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  // Next-PC mux. Select codes not listed fall back to the sequential PC.
  function automatic logic [31:0] pick_pc(
    input logic [2:0]  sel,
    input logic [31:0] pc_seq,
    input logic [31:0] t_pred,
    input logic [31:0] t_jal,
    input logic [31:0] t_jalr,
    input logic [31:0] t_br
  );
    case (sel)
      SEL_PRED: pick_pc = t_pred;
      SEL_JAL:  pick_pc = t_jal;
      SEL_JALR: pick_pc = t_jalr;
      SEL_BR:   pick_pc = t_br;
      default:  pick_pc = pc_seq;
    endcase
  endfunction

  logic [2:0]  eff_sel;
  logic        sel_illegal;
  logic        force_redirect;
  logic        advance;
  logic        nonseq;
  logic [31:0] pc_next;

  // ---- next-state decode (combinational) ----
  always_comb begin
    // A misprediction always wins. The select is steered to the resolved
    // branch target, whatever the predictor presented.
    eff_sel = predict_fail ? SEL_BR : pcmux_sel;

    // The illegal flag also catches a predict_fail that arrives with a select
    // other than 5. That combination means the predictor and E disagree.
    sel_illegal = (pcmux_sel == 3'd2) || (pcmux_sel == 3'd6) ||
                  (pcmux_sel == 3'd7) ||
                  (predict_fail && (pcmux_sel != SEL_BR));

    // JALR and branch resolution come from later stages. They must land even
    // under a load-use stall, because the stalled instructions are wrong-path.
    force_redirect = (eff_sel == SEL_JALR) || (eff_sel == SEL_BR);
    advance        = !stall || force_redirect;

    nonseq = (eff_sel == SEL_PRED) || (eff_sel == SEL_JAL) ||
             (eff_sel == SEL_JALR) || (eff_sel == SEL_BR);

    pc_next = pick_pc(eff_sel, pcF + 32'd4, pred_target, jal_target,
                      jalr_target, br_target);
  end

  // ---- fetch / squash registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pcF            <= RESET_PC;
      killF          <= 1'b1;
      killD          <= 1'b1;
      killE          <= 1'b1;
      killM          <= 1'b1;
      redirect       <= 1'b0;
      mispredict_cnt <= 16'd0;
      illegal_sel    <= 1'b0;
    end else begin
      if (advance) begin
        pcF   <= pc_next;
        killF <= 1'b0;
        // JALR resolves in D, so the instruction fetched behind it is
        // wrong-path. A mispredict resolves in E, so it also squashes the
        // instruction that was in D. Select 1 and select 3 resolve in F and
        // need no squash.
        killD <= killF | (eff_sel == SEL_JALR) | predict_fail;
        killE <= killD | predict_fail;
        killM <= killE;
      end else begin
        // Load-use stall: F and D hold their instructions and a bubble is
        // injected into E.
        killF <= killF;
        killD <= killD;
        killE <= 1'b1;
        killM <= killE;
      end

      redirect <= advance && nonseq;

      if (predict_fail) begin
        mispredict_cnt <= sat_inc16(mispredict_cnt);
      end

      if (sel_illegal) begin
        illegal_sel <= 1'b1;
      end
    end
  end

endmodule
